// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first magnitude comparator fed by per-digit g/e/l results.
// Optional one-hot digit checking: define SERIAL_CMP_ONEHOT_CHECK_EN.
module serial_magnitude_comparator #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             g_in,
  input  logic             e_in,
  input  logic             l_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t r_state;
  logic   r_dgt;
  logic   r_dlt;
  logic   r_err;
  logic   w_g;
  logic   w_l;
  logic   w_bad;
  logic   w_ngt;
  logic   w_nlt;
  logic   w_last;

`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
  // A malformed digit is counted but contributes "equal".
  assign w_bad = ~(( g_in & ~e_in & ~l_in) |
                   (~g_in &  e_in & ~l_in) |
                   (~g_in & ~e_in &  l_in));
  assign w_g   = g_in & ~w_bad;
  assign w_l   = l_in & ~w_bad;
  assign err   = r_err;
`else
  logic w_unused_e;
  assign w_unused_e = e_in;
  assign w_bad      = 1'b0;
  assign w_g        = g_in;
  assign w_l        = l_in & ~g_in;
  assign err        = 1'b0;
`endif

  // First non-equal digit wins; later digits cannot override it.
  assign w_ngt  = r_dgt | (~r_dlt & w_g);
  assign w_nlt  = r_dlt | (~r_dgt & w_l);
  assign w_last = (digit_cnt == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dgt     <= 1'b0;
      r_dlt     <= 1'b0;
      r_err     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      digit_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_state   <= S_CMP;
        r_dgt     <= 1'b0;
        r_dlt     <= 1'b0;
        r_err     <= 1'b0;
        busy      <= 1'b1;
        digit_cnt <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_CMP: begin
            if (in_valid) begin
              digit_cnt <= digit_cnt + 1'b1;
              r_dgt     <= w_ngt;
              r_dlt     <= w_nlt;
              r_err     <= r_err | w_bad;
              if (w_last) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                gt      <= w_ngt;
                lt      <= w_nlt;
                eq      <= ~w_ngt & ~w_nlt;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential downstream stage for the `two_bit_comparator` slice. It consumes one `g`/`e`/`l` result per valid cycle, most-significant 2-bit digit first, and resolves the full-width magnitude relation of two `2*DIGITS`-bit operands. The final greater/equal/less verdict is presented with a one-cycle `done` pulse and held until the next `start`.

## Interface
Parameters:
- `DIGITS`, default 4: number of 2-bit digit results per comparison, giving 8-bit operands by default. Legal range is 1..(2^`CNT_W` − 1).
- `CNT_W`, default 3: width of the digit counter. Must satisfy 2^`CNT_W` > `DIGITS`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a new comparison and clear the running verdict.
- `in_valid` in 1: `g_in`/`e_in`/`l_in` carry one digit result this cycle.
- `g_in` in 1: digit of a > digit of b.
- `e_in` in 1: digit of a == digit of b.
- `l_in` in 1: digit of a < digit of b.
- `busy` out 1: high in COMPARE.
- `done` out 1: one-cycle pulse when the verdict is final.
- `gt` out 1: final verdict a > b, registered.
- `eq` out 1: final verdict a == b, registered.
- `lt` out 1: final verdict a < b, registered.
- `digit_cnt` out `CNT_W`: number of digits accepted in the current comparison.
- `err` out 1: sticky invalid-encoding flag (see Configuration).

## Operation
The block has three states: IDLE, COMPARE and DONE. Reset enters IDLE.

IDLE:
- `start` moves to COMPARE.
- Entering COMPARE clears `digit_cnt` to 0, clears the internal decision to "equal so far" and clears `err`.
- `in_valid` is ignored in IDLE.

COMPARE:
- Each cycle with `in_valid`=1 accepts one digit and increments `digit_cnt`.
- While the decision is "equal so far":
  - `g_in`=1 latches GT.
  - `l_in`=1 latches LT.
  - `e_in`=1 keeps the decision at "equal so far".
- Once the decision is GT or LT, later digits are still counted but cannot change it, because the MSB decision dominates.
- When the accepted digit is number `DIGITS`, the next state is DONE.
- `start` during COMPARE aborts the current comparison and restarts it. The counter and decision clear, and any `in_valid` digit in that same cycle is discarded.

DONE:
- Lasts exactly one cycle, with `done`=1.
- `gt`/`eq`/`lt` are loaded on the clock edge that enters DONE. `eq`=1 only if every digit was equal.
- Always returns to IDLE.
- `start` asserted while in DONE is honoured: the next state is COMPARE, not IDLE.

Output rules:
- `gt`/`eq`/`lt` keep their values until the next DONE entry.
- `gt`/`eq`/`lt` are one-hot after the first completed comparison.
- Reset drives all outputs to 0.
- `digit_cnt` holds its final value after DONE and clears on `start`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `gt`=0, `eq`=0, `lt`=0, `digit_cnt`=0, `err`=0. Reset is effective immediately, including mid-comparison, and `done` is not emitted for an aborted comparison.
- Edge after `start`: `busy`=1.
- Edge of the `DIGITS`-th accepted digit: `busy`=0, `done`=1, and the verdict is valid in that same cycle.
- Minimum latency from `start` to `done` is `DIGITS`+1 cycles, with back-to-back `in_valid`.
- Gaps in `in_valid` stall the comparison. There is no timeout.
- Back-to-back comparisons: `start` during the `done` cycle gives zero idle cycles.

## Configuration
Macro: `SERIAL_CMP_ONEHOT_CHECK_EN`.

When defined:
- An accepted digit whose `{g_in,e_in,l_in}` is not one-hot sets `err`.
- `err` stays set until the next `start` or reset.
- The offending digit is counted but treated as equal.

When undefined:
- `err` is tied to 0.
- The decision uses priority `g_in` > `l_in` > `e_in`, with no checking.

## Test plan
- a=0x9C, b=0x9B, digits e,e,g,l back-to-back after `start` -> `done` in cycle 5 with `gt`=1, `eq`=0, `lt`=0, `digit_cnt`=4.
- a=b=0x5A, four e digits with an `in_valid` gap of 3 cycles after digit 2 -> `done` 8 cycles after `start`, `eq`=1.
- Digits l,g,g,g -> `lt`=1. The later g digits must not flip the verdict.
- `start`, 2 digits, `start` again, then 4 digits g,e,e,e -> a single `done`, `gt`=1, `digit_cnt`=4.
- `rst_n` pulsed low after 3 digits -> `busy`, `done`, `gt`, `eq`, `lt` and `digit_cnt` all 0 asynchronously. There is no `done` afterwards until a new `start`.
- With `SERIAL_CMP_ONEHOT_CHECK_EN` defined, digits e,{g,l both 1},e,e -> `err`=1, `eq`=1 at `done`. Without the macro, the same stimulus gives `gt`=1 and `err`=0.
